// File: rtl/clock_divider_bank.sv
// clock_divider_bank
// A bank of independent, runtime-programmable clock dividers. Each channel
// divides clk by its own divisor D. It produces a near-50%-duty slow_clk that
// is high for ceil(D/2) cycles and low for floor(D/2) cycles. It also produces
// a one-cycle tick on the first cycle of every period.
// A written divisor is only adopted at a period boundary, so a period is never
// cut short or stretched by a write. A global sync restarts every running
// channel at phase 0 on the same edge.
// All outputs come straight from flops; no input reaches an output
// combinationally.

module clock_divider_bank #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 1000,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                sync,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [WIDTH-1:0]    wr_div,
    output logic [CHANNELS-1:0] slow_clk,
    output logic [CHANNELS-1:0] tick
);

    // Divisor loaded into every channel at reset, sized to the counter width.
    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

    // The smallest divisor that can run; 0 and 1 park the channel.
    localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch

        state_t           state_r;
        logic [WIDTH-1:0] pend_div_r;   // divisor written by software
        logic [WIDTH-1:0] act_div_r;    // divisor governing the current period
        logic [WIDTH-1:0] cnt_r;        // phase within the current period
        logic             slow_r;
        logic             tick_r;

        logic             wr_hit_s;
        logic             pend_ok_s;
        logic             wrap_s;
        logic [WIDTH-1:0] cnt_inc_s;
        logic [WIDTH-1:0] high_len_s;

        // Decode the write target, restart eligibility, wrap point and high-phase length.
        always_comb begin
            wr_hit_s   = 1'b0;
            pend_ok_s  = 1'b0;
            wrap_s     = 1'b0;
            cnt_inc_s  = {WIDTH{1'b0}};
            high_len_s = {WIDTH{1'b0}};
            // A wr_ch at or above CHANNELS can never equal a channel index, so it writes nothing.
            if (wr_en && (wr_ch == CH_W'(gi))) begin
                wr_hit_s = 1'b1;
            end else begin
                wr_hit_s = 1'b0;
            end
            pend_ok_s  = (pend_div_r >= MIN_DIV);
            wrap_s     = (cnt_r == (act_div_r - WIDTH'(1)));
            cnt_inc_s  = cnt_r + WIDTH'(1);
            // The high phase is ceil(D/2). It is computed without overflow, so D = 2^WIDTH-1 works.
            high_len_s = act_div_r - (act_div_r >> 1);
        end

        // Pending divisor register: captures software writes, read only at period boundaries.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pend_div_r <= DEF_DIV;
            end else if (wr_hit_s) begin
                pend_div_r <= wr_div;
            end else begin
                pend_div_r <= pend_div_r;
            end
        end

        // Channel FSM: priority is en=0, then sync, then period wrap, then counting; outputs registered from next phase.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_r   <= ST_IDLE;
                act_div_r <= DEF_DIV;
                cnt_r     <= {WIDTH{1'b0}};
                slow_r    <= 1'b0;
                tick_r    <= 1'b0;
            end else if (!en[gi]) begin
                // Disabling truncates the period at once; act_div is kept.
                state_r   <= ST_IDLE;
                act_div_r <= act_div_r;
                cnt_r     <= {WIDTH{1'b0}};
                slow_r    <= 1'b0;
                tick_r    <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (pend_ok_s) begin
                            state_r   <= ST_RUN;
                            act_div_r <= pend_div_r;
                            cnt_r     <= {WIDTH{1'b0}};
                            slow_r    <= 1'b1;
                            tick_r    <= 1'b1;
                        end else begin
                            state_r   <= ST_IDLE;
                            act_div_r <= act_div_r;
                            cnt_r     <= {WIDTH{1'b0}};
                            slow_r    <= 1'b0;
                            tick_r    <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (sync || wrap_s) begin
                            // Period boundary, natural or forced: adopt the pending divisor or park.
                            if (pend_ok_s) begin
                                state_r   <= ST_RUN;
                                act_div_r <= pend_div_r;
                                cnt_r     <= {WIDTH{1'b0}};
                                slow_r    <= 1'b1;
                                tick_r    <= 1'b1;
                            end else begin
                                state_r   <= ST_IDLE;
                                act_div_r <= act_div_r;
                                cnt_r     <= {WIDTH{1'b0}};
                                slow_r    <= 1'b0;
                                tick_r    <= 1'b0;
                            end
                        end else begin
                            state_r   <= ST_RUN;
                            act_div_r <= act_div_r;
                            cnt_r     <= cnt_inc_s;
                            slow_r    <= (cnt_inc_s < high_len_s);
                            tick_r    <= 1'b0;
                        end
                    end
                    default: begin
                        state_r   <= ST_IDLE;
                        act_div_r <= act_div_r;
                        cnt_r     <= {WIDTH{1'b0}};
                        slow_r    <= 1'b0;
                        tick_r    <= 1'b0;
                    end
                endcase
            end
        end

        assign slow_clk[gi] = slow_r;
        assign tick[gi]     = tick_r;

    end : g_ch

endmodule : clock_divider_bank

// File: tb/tb_clock_divider_bank.sv
// tb_clock_divider_bank
// Directed-vector bench for clock_divider_bank. The main instance uses the
// default parameters. A small 3-channel instance exercises out-of-range write
// indices, which a 2-bit wr_ch can express.

module tb_clock_divider_bank;

    localparam int CH = 4;
    localparam int W  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] en;
    logic          sync;
    logic          wr_en;
    logic [1:0]    wr_ch;
    logic [W-1:0]  wr_div;
    logic [CH-1:0] slow_clk;
    logic [CH-1:0] tick;

    logic [2:0]    en3;
    logic          sync3;
    logic          wr_en3;
    logic [1:0]    wr_ch3;
    logic [7:0]    wr_div3;
    logic [2:0]    slow3;
    logic [2:0]    tick3;

    int errors = 0;
    int checks = 0;

    logic [CH-1:0] cap_s [0:2047];
    logic [CH-1:0] cap_t [0:2047];

    clock_divider_bank #(.CHANNELS(4), .WIDTH(16), .DEFAULT_DIV(1000)) u_dut (
        .clk(clk), .rst(rst), .en(en), .sync(sync), .wr_en(wr_en),
        .wr_ch(wr_ch), .wr_div(wr_div), .slow_clk(slow_clk), .tick(tick)
    );

    clock_divider_bank #(.CHANNELS(3), .WIDTH(8), .DEFAULT_DIV(4)) u_dut3 (
        .clk(clk), .rst(rst), .en(en3), .sync(sync3), .wr_en(wr_en3),
        .wr_ch(wr_ch3), .wr_div(wr_div3), .slow_clk(slow3), .tick(tick3)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample_n(input int n);
        for (int k = 0; k < n; k++) begin
            cyc();
            cap_s[k] = slow_clk;
            cap_t[k] = tick;
        end
    endtask

    task automatic wr(input int ch, input int d);
        wr_en  = 1'b1;
        wr_ch  = 2'(ch);
        wr_div = 16'(d);
        cyc();
        wr_en  = 1'b0;
    endtask

    // First captured sample ends up in bit n-1.
    function automatic logic [63:0] pack_s(input int ch, input int n);
        logic [63:0] v = 64'd0;
        for (int k = 0; k < n; k++) v = {v[62:0], cap_s[k][ch]};
        return v;
    endfunction

    function automatic logic [63:0] pack_t(input int ch, input int n);
        logic [63:0] v = 64'd0;
        for (int k = 0; k < n; k++) v = {v[62:0], cap_t[k][ch]};
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1; en = 4'b0000; sync = 1'b0; wr_en = 1'b0; wr_ch = 2'd0; wr_div = 16'd0;
        en3 = 3'b000; sync3 = 1'b0; wr_en3 = 1'b0; wr_ch3 = 2'd0; wr_div3 = 8'd0;
        cyc(); cyc();
        checks++;
        if ({slow_clk, tick} !== 8'h00) begin
            errors++; $display("FAIL reset_hold: got %b expected 00000000", {slow_clk, tick});
        end
        checks++;
        if ({slow3, tick3} !== 6'b000000) begin
            errors++; $display("FAIL reset_hold3: got %b expected 000000", {slow3, tick3});
        end
        rst = 1'b0;
        cyc(); cyc(); cyc();
        checks++;
        if ({slow_clk, tick} !== 8'h00) begin
            errors++; $display("FAIL idle_after_reset: got %b expected 00000000", {slow_clk, tick});
        end
    endtask

    task automatic test_default_div();
        int highs = 0;
        int ticks = 0;
        logic [CH-1:0] others = '0;
        en = 4'b0001;
        sample_n(2000);
        for (int k = 0; k < 2000; k++) begin
            if (k < 1000 && cap_s[k][0]) highs++;
            if (cap_t[k][0]) ticks++;
            others = others | ((cap_s[k] | cap_t[k]) & 4'b1110);
        end
        checks++;
        if ({cap_s[0][0], cap_t[0][0]} !== 2'b11) begin
            errors++; $display("FAIL def_first: got %b expected 11", {cap_s[0][0], cap_t[0][0]});
        end
        checks++;
        if (highs !== 500) begin
            errors++; $display("FAIL def_high_count: got %0d expected 500", highs);
        end
        checks++;
        if ({cap_s[499][0], cap_s[500][0], cap_s[999][0], cap_s[1000][0]} !== 4'b1001) begin
            errors++; $display("FAIL def_edges: got %b expected 1001",
                               {cap_s[499][0], cap_s[500][0], cap_s[999][0], cap_s[1000][0]});
        end
        checks++;
        if (ticks !== 2 || cap_t[1000][0] !== 1'b1) begin
            errors++; $display("FAIL def_ticks: got %0d (t1000=%b) expected 2 (t1000=1)", ticks, cap_t[1000][0]);
        end
        checks++;
        if (others !== 4'b0000) begin
            errors++; $display("FAIL def_others: got %b expected 0000", others);
        end
    endtask

    task automatic test_odd_div();
        en = 4'b0000;
        cyc();
        wr(1, 5);
        en = 4'b0010;
        sample_n(10);
        checks++;
        if (pack_s(1, 10) !== 64'b1110011100) begin
            errors++; $display("FAIL odd_slow: got %b expected 1110011100", pack_s(1, 10));
        end
        checks++;
        if (pack_t(1, 10) !== 64'b1000010000) begin
            errors++; $display("FAIL odd_tick: got %b expected 1000010000", pack_t(1, 10));
        end
    endtask

    task automatic test_retarget();
        en = 4'b0000;
        cyc();
        wr(0, 4);
        en = 4'b0001;
        cyc();
        checks++;
        if ({slow_clk[0], tick[0]} !== 2'b11) begin
            errors++; $display("FAIL rt_start: got %b expected 11", {slow_clk[0], tick[0]});
        end
        cyc();
        wr(0, 6);
        checks++;
        if ({slow_clk[0], tick[0]} !== 2'b00) begin
            errors++; $display("FAIL rt_cnt2: got %b expected 00", {slow_clk[0], tick[0]});
        end
        sample_n(13);
        checks++;
        if (pack_s(0, 13) !== 64'b0111000111000) begin
            errors++; $display("FAIL rt_slow: got %b expected 0111000111000", pack_s(0, 13));
        end
        checks++;
        if (pack_t(0, 13) !== 64'b0100000100000) begin
            errors++; $display("FAIL rt_tick: got %b expected 0100000100000", pack_t(0, 13));
        end
    endtask

    task automatic test_sync();
        en = 4'b0000;
        cyc();
        wr(0, 4);
        wr(1, 6);
        en = 4'b0001;
        cyc(); cyc();
        en = 4'b0011;
        cyc(); cyc(); cyc();
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        checks++;
        if ({slow_clk, tick} !== 8'b0011_0011) begin
            errors++; $display("FAIL sync_edge: got %b expected 00110011", {slow_clk, tick});
        end
        sample_n(12);
        checks++;
        if (pack_s(0, 12) !== 64'b100110011001 || pack_t(0, 12) !== 64'b000100010001) begin
            errors++; $display("FAIL sync_ch0: got %b/%b expected 100110011001/000100010001",
                               pack_s(0, 12), pack_t(0, 12));
        end
        checks++;
        if (pack_s(1, 12) !== 64'b110001110001 || pack_t(1, 12) !== 64'b000001000001) begin
            errors++; $display("FAIL sync_ch1: got %b/%b expected 110001110001/000001000001",
                               pack_s(1, 12), pack_t(1, 12));
        end
    endtask

    task automatic test_div_one();
        wr(0, 1);
        checks++;
        if ({slow_clk[0], tick[0]} !== 2'b10) begin
            errors++; $display("FAIL d1_finish: got %b expected 10", {slow_clk[0], tick[0]});
        end
        sample_n(6);
        checks++;
        if (pack_s(0, 6) !== 64'd0 || pack_t(0, 6) !== 64'd0) begin
            errors++; $display("FAIL d1_parked: got %b/%b expected 000000/000000", pack_s(0, 6), pack_t(0, 6));
        end
        wr(0, 3);
        checks++;
        if ({slow_clk[0], tick[0]} !== 2'b00) begin
            errors++; $display("FAIL d3_write_edge: got %b expected 00", {slow_clk[0], tick[0]});
        end
        sample_n(6);
        checks++;
        if (pack_s(0, 6) !== 64'b110110 || pack_t(0, 6) !== 64'b100100) begin
            errors++; $display("FAIL d3_restart: got %b/%b expected 110110/100100", pack_s(0, 6), pack_t(0, 6));
        end
    endtask

    task automatic test_en_drop();
        cyc();
        checks++;
        if ({slow_clk[0], tick[0]} !== 2'b11) begin
            errors++; $display("FAIL drop_pre: got %b expected 11", {slow_clk[0], tick[0]});
        end
        en = 4'b0010;
        cyc();
        checks++;
        if ({slow_clk[0], tick[0]} !== 2'b00) begin
            errors++; $display("FAIL drop_now: got %b expected 00", {slow_clk[0], tick[0]});
        end
        en = 4'b0011;
        cyc();
        checks++;
        if ({slow_clk[0], tick[0]} !== 2'b11) begin
            errors++; $display("FAIL drop_reenable: got %b expected 11", {slow_clk[0], tick[0]});
        end
    endtask

    task automatic test_async_reset();
        int mid_ticks = 0;
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({slow_clk, tick} !== 8'h00) begin
            errors++; $display("FAIL async_rst: got %b expected 00000000", {slow_clk, tick});
        end
        #2;
        rst = 1'b0;
        sample_n(1001);
        for (int k = 1; k < 1000; k++) begin
            if (cap_t[k][1:0] != 2'b00) mid_ticks++;
        end
        checks++;
        if (cap_t[0][1:0] !== 2'b11 || cap_t[1000][1:0] !== 2'b11 || mid_ticks !== 0) begin
            errors++; $display("FAIL rst_default_tick: got t0=%b t1000=%b mid=%0d expected 11 11 0",
                               cap_t[0][1:0], cap_t[1000][1:0], mid_ticks);
        end
        checks++;
        if ({cap_s[499][1:0], cap_s[500][1:0]} !== 4'b1100) begin
            errors++; $display("FAIL rst_default_duty: got %b expected 1100", {cap_s[499][1:0], cap_s[500][1:0]});
        end
    endtask

    task automatic test_wr_range();
        logic [7:0] v0 = 8'd0;
        logic [7:0] v1 = 8'd0;
        logic [7:0] v2 = 8'd0;
        wr_en3 = 1'b1; wr_ch3 = 2'd3; wr_div3 = 8'd2;
        cyc();
        wr_en3 = 1'b0;
        en3 = 3'b111;
        for (int k = 0; k < 8; k++) begin
            cyc();
            v0 = {v0[6:0], slow3[0]};
            v1 = {v1[6:0], slow3[1]};
            v2 = {v2[6:0], slow3[2]};
        end
        checks++;
        if ({v0, v1, v2} !== {8'b11001100, 8'b11001100, 8'b11001100}) begin
            errors++; $display("FAIL wr_out_of_range: got %b %b %b expected 11001100 x3", v0, v1, v2);
        end
    endtask

    initial begin
        test_reset();
        test_default_div();
        test_odd_div();
        test_retarget();
        test_sync();
        test_div_one();
        test_en_drop();
        test_async_reset();
        test_wr_range();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_clock_divider_bank
